instruction_fetch: RTL and testbench

//  Front of the MIPS datapath. Owns the PC and fetches 32-bit instructions from instruction memory over a req/ready handshake.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/next_pc_logic.sv | 48 ++++
 rtl/instruction_fetch.sv | 108 ++++++++++
 tb/tb_instruction_fetch.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the MIPS datapath slice.
//   - Primary opcode values (Instruction[31:26]) used by the decoder.
//   - fetch_state_t: states of the instruction fetch controller.
//   - DEFAULT_RESET_PC: PC value loaded on reset unless overridden.
//   - opcode_of(): extracts the primary opcode field from an instruction word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// next_pc_logic
//   Purely combinational next-PC selection for the fetch stage.
// Ports
//   pc          in   PC_WIDTH  address of the instruction being retired
//   instruction in   26        low 26 bits of that instruction (jump index,
//                              and the 16-bit branch immediate in [15:0])
//   jump        in   1         decoder says this is a J-type jump
//   branch      in   1         decoder says this is a conditional branch
//   branch_cond in   1         ALU says the branch condition holds
//   pc_plus4    out  PC_WIDTH  pc + 4, wrapping
//   next_pc     out  PC_WIDTH  selected fetch address for the next instruction
module next_pc_logic #(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [25:0]         instruction,
  input  logic                jump,
  input  logic                branch,
  input  logic                branch_cond,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] branch_offset;
  logic [PC_WIDTH-1:0] branch_target;

  assign pc_plus4 = pc + PC_WIDTH'(4);

  // Jumps keep the region bits of the delay-slot address and replace the rest
  // with the word index from the instruction.
  assign jump_target = {pc_plus4[PC_WIDTH-1:28], instruction[25:0], 2'b00};

  // Branch immediate is a signed word offset relative to pc + 4.
  assign branch_offset = {{(PC_WIDTH-18){instruction[15]}}, instruction[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_offset;

  // Jump is checked first so it wins when the decoder raises both.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && branch_cond) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Front of the MIPS datapath. Owns the PC, fetches instructions over a
//   req/ready handshake, holds each one in an instruction register until the
//   downstream stage retires it, then moves the PC to the selected next address.
// Ports
//   clk, reset   clock and synchronous active-high reset
//   imem_req     out  fetch request, high for the whole FETCH state
//   imem_addr    out  word-aligned fetch address (= PC)
//   imem_ready   in   memory accepts; imem_rdata valid in the same cycle
//   imem_rdata   in   fetched instruction word
//   Instruction  out  instruction register
//   Opcode       out  Instruction[31:26]
//   PC           out  address of the held instruction
//   PCPlus4      out  PC + 4, wrapping
//   inst_valid   out  Instruction/Opcode/PC are valid (HOLD state)
//   inst_ack     in   downstream retires the held instruction
//   Jump, Branch, BranchCond  in  next-PC controls, used only on retire
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int                PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         Instruction,
  output logic [5:0]          Opcode,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PCPlus4,
  output logic                inst_valid,
  input  logic                inst_ack,
  input  logic                Jump,
  input  logic                Branch,
  input  logic                BranchCond
);

  fetch_state_t        state;
  fetch_state_t        next_state;
  logic [PC_WIDTH-1:0] next_pc;

  next_pc_logic #(
    .PC_WIDTH(PC_WIDTH)
  ) u_next_pc (
    .pc          (PC),
    .instruction (Instruction[25:0]),
    .jump        (Jump),
    .branch      (Branch),
    .branch_cond (BranchCond),
    .pc_plus4    (PCPlus4),
    .next_pc     (next_pc)
  );

  // Low address bits are forced to zero so a misconfigured reset PC can never
  // produce an unaligned fetch.
  assign imem_addr = {PC[PC_WIDTH-1:2], 2'b00};
  assign Opcode    = opcode_of(Instruction);

  // State, PC and instruction register. Reset wins over any same-cycle
  // ready or ack, so a word arriving with reset is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      PC          <= RESET_PC;
      Instruction <= 32'h0;
    end else begin
      state <= next_state;
      if (state == FETCH && imem_ready) begin
        Instruction <= imem_rdata;
      end
      if (state == HOLD && inst_ack) begin
        PC <= next_pc;
      end
    end
  end

  // Handshake outputs are decoded from the state alone, so imem_req and
  // inst_valid never depend combinationally on memory or downstream inputs.
  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state)
      IDLE: begin
        next_state = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        inst_valid = 1'b1;
        if (inst_ack) begin
          next_state = FETCH;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch
//   Directed bench for instruction_fetch: walks the PC through sequential,
//   waited, branch, jump, wraparound and reset scenarios with hand-computed
//   expected addresses.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [5:0]  Opcode;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        inst_valid;
  logic        inst_ack;
  logic        Jump;
  logic        Branch;
  logic        BranchCond;

  int compared;
  int mismatched;

  localparam logic [31:0] ADDI_W  = 32'h2008_0005;
  localparam logic [31:0] BEQ_M2  = 32'h1000_FFFE;

  instruction_fetch #(
    .PC_WIDTH (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .Instruction (Instruction),
    .Opcode      (Opcode),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .inst_valid  (inst_valid),
    .inst_ack    (inst_ack),
    .Jump        (Jump),
    .Branch      (Branch),
    .BranchCond  (BranchCond)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drives all non-reset inputs at once.
  task automatic applyStimulus(input logic ready, input logic [31:0] rdata,
                               input logic ack, input logic j, input logic b,
                               input logic c);
    imem_ready = ready;
    imem_rdata = rdata;
    inst_ack   = ack;
    Jump       = j;
    Branch     = b;
    BranchCond = c;
  endtask

  // Advance one clock; outputs are examined 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: expects to start in FETCH at addr, waits the given
  // number of not-ready cycles (with a stray ack that must be ignored),
  // delivers instr, then retires it with the given controls and checks the
  // following fetch address.
  task automatic fetchOne(input string tag, input logic [31:0] addr,
                          input logic [31:0] instr, input int waits,
                          input logic j, input logic b, input logic c,
                          input logic [31:0] next_addr);
    logic [31:0] op_exp;
    op_exp = {26'h0, instr[31:26]};
    checkOutput({tag, " req"},  {31'h0, imem_req}, 32'h1);
    checkOutput({tag, " addr"}, imem_addr, addr);
    for (int w = 0; w < waits; w++) begin
      applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      checkOutput({tag, " wait req"},   {31'h0, imem_req}, 32'h1);
      checkOutput({tag, " wait addr"},  imem_addr, addr);
      checkOutput({tag, " wait valid"}, {31'h0, inst_valid}, 32'h0);
    end
    applyStimulus(1'b1, instr, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput({tag, " valid"},   {31'h0, inst_valid}, 32'h1);
    checkOutput({tag, " hold req"}, {31'h0, imem_req}, 32'h0);
    checkOutput({tag, " instr"},   Instruction, instr);
    checkOutput({tag, " opcode"},  {26'h0, Opcode}, op_exp);
    checkOutput({tag, " pc"},      PC, addr);
    checkOutput({tag, " pc+4"},    PCPlus4, addr + 32'd4);
    // ready with junk data while holding must not disturb the register
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, j, b, c);
    step();
    checkOutput({tag, " ack valid"}, {31'h0, inst_valid}, 32'h0);
    checkOutput({tag, " ack req"},   {31'h0, imem_req}, 32'h1);
    checkOutput({tag, " next addr"}, imem_addr, next_addr);
    checkOutput({tag, " instr kept"}, Instruction, instr);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("rst req",   {31'h0, imem_req}, 32'h0);
    checkOutput("rst valid", {31'h0, inst_valid}, 32'h0);
    checkOutput("rst pc",    PC, 32'h0);
    checkOutput("rst instr", Instruction, 32'h0);

    // IDLE lasts exactly one cycle after reset drops
    reset = 1'b0;
    checkOutput("idle req", {31'h0, imem_req}, 32'h0);
    step();

    // Sequential zero-wait fetches, then a 3-cycle memory stall at 0x10
    fetchOne("seq0", 32'h0000_0000, ADDI_W, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
    fetchOne("seq1", 32'h0000_0004, ADDI_W, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0008);
    fetchOne("seq2", 32'h0000_0008, ADDI_W, 0, 1'b0, 1'b0, 1'b0, 32'h0000_000C);
    fetchOne("seq3", 32'h0000_000C, ADDI_W, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0010);
    fetchOne("wait", 32'h0000_0010, ADDI_W, 3, 1'b0, 1'b0, 1'b0, 32'h0000_0014);

    // J index 0x10 -> 0x40; BEQ -2 taken -> 0x3C; back to 0x40; not taken -> 0x44
    fetchOne("j40",   32'h0000_0014, 32'h0800_0010, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
    fetchOne("beqT",  32'h0000_0040, BEQ_M2,        0, 1'b0, 1'b1, 1'b1, 32'h0000_003C);
    fetchOne("j40b",  32'h0000_003C, 32'h0800_0010, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
    fetchOne("beqNT", 32'h0000_0040, BEQ_M2,        0, 1'b0, 1'b1, 1'b0, 32'h0000_0044);

    // Reach 0x1000_0000, then jump with Branch also raised: Jump wins
    fetchOne("jmax",  32'h0000_0044, 32'h0BFF_FFFF, 0, 1'b1, 1'b0, 1'b0, 32'h0FFF_FFFC);
    fetchOne("cross", 32'h0FFF_FFFC, ADDI_W,        0, 1'b0, 1'b0, 1'b0, 32'h1000_0000);
    fetchOne("jprio", 32'h1000_0000, 32'h0800_0100, 0, 1'b1, 1'b1, 1'b1, 32'h1000_0400);

    // Reset in the same cycle as imem_ready: word discarded
    reset = 1'b1;
    applyStimulus(1'b1, ADDI_W, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("rstF req",   {31'h0, imem_req}, 32'h0);
    checkOutput("rstF valid", {31'h0, inst_valid}, 32'h0);
    checkOutput("rstF pc",    PC, 32'h0);
    checkOutput("rstF instr", Instruction, 32'h0);
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rstF idle", {31'h0, imem_req}, 32'h0);
    step();
    checkOutput("rstF refetch req",  {31'h0, imem_req}, 32'h1);
    checkOutput("rstF refetch addr", imem_addr, 32'h0);

    // Reset in HOLD alongside an ack that would have jumped: ack lost
    applyStimulus(1'b1, 32'h0800_0010, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("rstH pre valid", {31'h0, inst_valid}, 32'h1);
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("rstH valid", {31'h0, inst_valid}, 32'h0);
    checkOutput("rstH req",   {31'h0, imem_req}, 32'h0);
    checkOutput("rstH pc",    PC, 32'h0);
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rstH idle", {31'h0, imem_req}, 32'h0);
    step();

    // Wraparound: branch back to 0xFFFF_FFFC, then +4 wraps to 0
    fetchOne("wrapB", 32'h0000_0000, BEQ_M2, 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    fetchOne("wrap",  32'hFFFF_FFFC, ADDI_W, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
